// File: rtl/hl_reset_pkg.sv
// hl_reset_pkg: shared state encodings and default timing constants for the
// Hermes Lite reset sequencer.
package hl_reset_pkg;

    // Sequencer states; the numeric values are exported on seq_state for LEDs.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        FILTER    = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } seq_state_e;

    // Default timing, in rstclk cycles.
    localparam int NSTAGE_DEF       = 4;
    localparam int CNT_W_DEF        = 16;
    localparam int LOCK_FILTER_DEF  = 256;
    localparam int STAGE_DELAY_DEF  = 1000;
    localparam int DEBOUNCE_DEF     = 64;
    localparam int LOCK_TIMEOUT_DEF = 50000;

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: request inputs and reset/status outputs of the reset
// sequencer. The master side is the sequencer, the slave side is the board
// wrapper that feeds it and consumes the per-domain resets.
//
// Request semantics: soft_reset is sampled on every rstclk edge and each
// cycle it is high counts as one re-sequence request; there is no
// acknowledge. pll_locked and ext_reset_n are asynchronous levels and are
// synchronised inside the sequencer.
interface reset_sequencer_if #(
    parameter int NSTAGE = 4
) ();
    logic              pll_locked;
    logic              ext_reset_n;
    logic              soft_reset;
    logic [NSTAGE-1:0] stage_rst_n;
    logic              seq_done;
    logic              lock_timeout;
    logic [7:0]        lock_loss_cnt;
    logic [1:0]        seq_state;

    modport master (
        input  pll_locked,
        input  ext_reset_n,
        input  soft_reset,
        output stage_rst_n,
        output seq_done,
        output lock_timeout,
        output lock_loss_cnt,
        output seq_state
    );

    modport slave (
        output pll_locked,
        output ext_reset_n,
        output soft_reset,
        input  stage_rst_n,
        input  seq_done,
        input  lock_timeout,
        input  lock_loss_cnt,
        input  seq_state
    );
endinterface

// File: rtl/sync_debounce.sv
// sync_debounce: 2-FF synchroniser for an active-low asynchronous input,
// followed by a low-time counter that emits a single-cycle request once the
// synchronised input has been low for DEBOUNCE consecutive cycles. The
// request re-arms only after the synchronised input returns high.
module sync_debounce
    import hl_reset_pkg::*;
#(
    parameter int DEBOUNCE = DEBOUNCE_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic req
);

    localparam int            DW   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DW-1:0] LAST = DW'(DEBOUNCE - 1);

    logic          meta;
    logic [DW-1:0] cnt;
    logic          fired;

    // Two-flop synchroniser; both flops clear to 0 on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta     <= 1'b0;
            sync_out <= 1'b0;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

    // Count synchronised low cycles (saturating) and remember that the
    // request for this low period has already been issued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            fired <= 1'b0;
        end else if (sync_out) begin
            cnt   <= '0;
            fired <= 1'b0;
        end else begin
            if (cnt != LAST) begin
                cnt <= cnt + 1'b1;
            end
            if (req) begin
                fired <= 1'b1;
            end
        end
    end

    // Request is high in the cycle the count sits at DEBOUNCE-1 with the
    // input still low, and only once per low period.
    assign req = !sync_out && (cnt == LAST) && !fired;

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: waits for a stable IF PLL lock, then releases NSTAGE
// active-low reset domains one at a time, STAGE_DELAY cycles apart. Loss of
// lock, a debounced external reset or a soft_reset pulse restarts the whole
// sequence from WAIT_LOCK.
module reset_sequencer
    import hl_reset_pkg::*;
#(
    parameter int NSTAGE       = NSTAGE_DEF,
    parameter int CNT_W        = CNT_W_DEF,
    parameter int LOCK_FILTER  = LOCK_FILTER_DEF,
    parameter int STAGE_DELAY  = STAGE_DELAY_DEF,
    parameter int DEBOUNCE     = DEBOUNCE_DEF,
    parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
    input  logic               rstclk,
    input  logic               rst_n,
    reset_sequencer_if.master  bus     // must be instantiated with the same NSTAGE
);

    localparam int IW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;

    // Thresholds truncated to the shared counter width.
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(LOCK_TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] STG_LAST   = CNT_W'(STAGE_DELAY - 1);
    localparam logic [IW-1:0]    LAST_IDX   = IW'(NSTAGE - 1);

    logic lk_m;
    logic lk_s;
    logic ext_s;
    logic ext_req;
    logic abort;

    seq_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [IW-1:0]     idx;
    logic [NSTAGE-1:0] stage_q;
    logic              done_q;
    logic              timeout_q;
    logic [7:0]        loss_q;

    // Plain 2-FF synchroniser for the PLL lock; no debounce is wanted here
    // because any lock drop must restart the sequence.
    always_ff @(posedge rstclk) begin
        if (!rst_n) begin
            lk_m <= 1'b0;
            lk_s <= 1'b0;
        end else begin
            lk_m <= bus.pll_locked;
            lk_s <= lk_m;
        end
    end

    sync_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_ext_db (
        .clk      (rstclk),
        .rst_n    (rst_n),
        .async_in (bus.ext_reset_n),
        .sync_out (ext_s),
        .req      (ext_req)
    );

    // Any of these restarts the sequence when outside WAIT_LOCK.
    assign abort = !lk_s || ext_req || bus.soft_reset;

    // Sequencer FSM with registered outputs. An abort outside WAIT_LOCK
    // takes priority over all progress; while the button is held (ext_s=0)
    // FILTER and RELEASE stall so the domains stay in reset.
    always_ff @(posedge rstclk) begin
        if (!rst_n) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            idx       <= '0;
            stage_q   <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            loss_q    <= '0;
        end else if (state != WAIT_LOCK && abort) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            idx     <= '0;
            stage_q <= '0;
            done_q  <= 1'b0;
            // Only a lock drop while fully running counts as a lock loss.
            if (state == RUN && !lk_s && loss_q != 8'hFF) begin
                loss_q <= loss_q + 8'd1;
            end
        end else begin
            case (state)
                WAIT_LOCK: begin
                    if (ext_req || bus.soft_reset) begin
                        cnt <= '0;
                    end else if (lk_s) begin
                        state <= FILTER;
                        cnt   <= '0;
                    end else if (cnt != TIMEOUT_C) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == TIMEOUT_M1) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                FILTER: begin
                    if (ext_s) begin
                        if (cnt == FILT_LAST) begin
                            state <= RELEASE;
                            cnt   <= '0;
                            idx   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (ext_s) begin
                        if (cnt == STG_LAST) begin
                            stage_q[idx] <= 1'b1;
                            cnt          <= '0;
                            if (idx == LAST_IDX) begin
                                state  <= RUN;
                                done_q <= 1'b1;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RUN: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state <= WAIT_LOCK;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.stage_rst_n   = stage_q;
    assign bus.seq_done      = done_q;
    assign bus.lock_timeout  = timeout_q;
    assign bus.lock_loss_cnt = loss_q;
    assign bus.seq_state     = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed bench for the reset sequencer with short
// timing (LOCK_FILTER=8, STAGE_DELAY=10, DEBOUNCE=4, LOCK_TIMEOUT=100).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_reset_sequencer;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    reset_sequencer_if #(.NSTAGE(4)) bus ();

    reset_sequencer #(
        .NSTAGE       (4),
        .CNT_W        (16),
        .LOCK_FILTER  (8),
        .STAGE_DELAY  (10),
        .DEBOUNCE     (4),
        .LOCK_TIMEOUT (100)
    ) dut (
        .rstclk (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance n rising edges and land 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for seq_done; an expired bound shows up as a miscompare.
    task automatic wait_run(input int bound);
        int n;
        n = 0;
        while (bus.seq_done !== 1'b1 && n < bound) begin
            tick(1);
            n++;
        end
        chk("wait_run", {31'd0, bus.seq_done}, 32'd1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n           = 1'b0;
        bus.pll_locked  = 1'b0;
        bus.ext_reset_n = 1'b1;
        bus.soft_reset  = 1'b0;
        tick(3);

        // Reset state
        chk("rst_stage", 32'(bus.stage_rst_n), 32'h0);
        chk("rst_done", 32'(bus.seq_done), 32'h0);
        chk("rst_timeout", 32'(bus.lock_timeout), 32'h0);
        chk("rst_loss", 32'(bus.lock_loss_cnt), 32'h0);
        chk("rst_state", 32'(bus.seq_state), 32'h0);

        // Power-up: lock sampled at edge 1, first release at edge 21
        rst_n          = 1'b1;
        bus.pll_locked = 1'b1;
        tick(20);
        chk("pu_e20_stage", 32'(bus.stage_rst_n), 32'h0);
        chk("pu_e20_state", 32'(bus.seq_state), 32'h2);
        tick(1);
        chk("pu_e21_stage", 32'(bus.stage_rst_n), 32'h1);
        tick(9);
        chk("pu_e30_stage", 32'(bus.stage_rst_n), 32'h1);
        tick(1);
        chk("pu_e31_stage", 32'(bus.stage_rst_n), 32'h3);
        tick(10);
        chk("pu_e41_stage", 32'(bus.stage_rst_n), 32'h7);
        tick(9);
        chk("pu_e50_done", 32'(bus.seq_done), 32'h0);
        tick(1);
        chk("pu_e51_stage", 32'(bus.stage_rst_n), 32'hF);
        chk("pu_e51_done", 32'(bus.seq_done), 32'h1);
        chk("pu_e51_state", 32'(bus.seq_state), 32'h3);

        // soft_reset in RUN, then a one-cycle lock glitch at filter count 5
        bus.soft_reset = 1'b1;
        tick(1);
        bus.soft_reset = 1'b0;
        chk("sr_run_stage", 32'(bus.stage_rst_n), 32'h0);
        chk("sr_run_state", 32'(bus.seq_state), 32'h0);
        tick(4);
        bus.pll_locked = 1'b0;
        tick(1);
        bus.pll_locked = 1'b1;
        tick(1);
        chk("gl_e7_state", 32'(bus.seq_state), 32'h1);
        tick(1);
        chk("gl_e8_state", 32'(bus.seq_state), 32'h0);
        tick(1);
        chk("gl_e9_state", 32'(bus.seq_state), 32'h1);
        tick(7);
        chk("gl_e16_state", 32'(bus.seq_state), 32'h1);
        tick(1);
        chk("gl_e17_state", 32'(bus.seq_state), 32'h2);
        chk("gl_loss", 32'(bus.lock_loss_cnt), 32'h0);

        // soft_reset in RELEASE right after stage 1 is released
        tick(10);
        chk("rel_e27_stage", 32'(bus.stage_rst_n), 32'h1);
        tick(10);
        chk("rel_e37_stage", 32'(bus.stage_rst_n), 32'h3);
        bus.soft_reset = 1'b1;
        tick(1);
        bus.soft_reset = 1'b0;
        chk("sr_rel_stage", 32'(bus.stage_rst_n), 32'h0);
        chk("sr_rel_state", 32'(bus.seq_state), 32'h0);
        chk("sr_rel_done", 32'(bus.seq_done), 32'h0);
        tick(1);
        chk("sr_rel_refilter", 32'(bus.seq_state), 32'h1);
        wait_run(100);

        // Lock loss in RUN: outputs drop 3 edges after the input edge
        bus.pll_locked = 1'b0;
        tick(2);
        chk("ll_e2_stage", 32'(bus.stage_rst_n), 32'hF);
        chk("ll_e2_done", 32'(bus.seq_done), 32'h1);
        tick(1);
        chk("ll_e3_stage", 32'(bus.stage_rst_n), 32'h0);
        chk("ll_e3_done", 32'(bus.seq_done), 32'h0);
        chk("ll_e3_state", 32'(bus.seq_state), 32'h0);
        chk("ll_e3_loss", 32'(bus.lock_loss_cnt), 32'h1);
        bus.pll_locked = 1'b1;
        wait_run(100);

        // Button: 3-cycle low pulse is ignored
        bus.ext_reset_n = 1'b0;
        tick(3);
        bus.ext_reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("btn_short_done", 32'(bus.seq_done), 32'h1);
        end

        // Button: 20-cycle hold aborts, keeps resets low, re-sequences on release
        bus.ext_reset_n = 1'b0;
        tick(5);
        chk("btn_e5_stage", 32'(bus.stage_rst_n), 32'hF);
        tick(1);
        chk("btn_e6_stage", 32'(bus.stage_rst_n), 32'h0);
        chk("btn_e6_state", 32'(bus.seq_state), 32'h0);
        tick(1);
        chk("btn_e7_state", 32'(bus.seq_state), 32'h1);
        tick(13);
        bus.ext_reset_n = 1'b1;
        tick(2);
        chk("btn_e22_stage", 32'(bus.stage_rst_n), 32'h0);
        chk("btn_e22_state", 32'(bus.seq_state), 32'h1);
        tick(7);
        chk("btn_e29_state", 32'(bus.seq_state), 32'h1);
        tick(1);
        chk("btn_e30_state", 32'(bus.seq_state), 32'h2);
        tick(10);
        chk("btn_e40_stage", 32'(bus.stage_rst_n), 32'h1);
        wait_run(100);
        chk("btn_loss", 32'(bus.lock_loss_cnt), 32'h1);

        // Forced lock losses 2..300: counter saturates at 255
        for (int i = 2; i <= 300; i++) begin
            bus.pll_locked = 1'b0;
            tick(3);
            bus.pll_locked = 1'b1;
            if (i == 254) chk("loss_254", 32'(bus.lock_loss_cnt), 32'd254);
            if (i == 255) chk("loss_255", 32'(bus.lock_loss_cnt), 32'd255);
            wait_run(100);
        end
        chk("loss_sat", 32'(bus.lock_loss_cnt), 32'd255);
        chk("loss_no_timeout", 32'(bus.lock_timeout), 32'h0);

        // No lock: timeout at edge 100, sticky through a later sequence
        rst_n          = 1'b0;
        bus.pll_locked = 1'b0;
        tick(2);
        chk("to_rst_loss", 32'(bus.lock_loss_cnt), 32'h0);
        rst_n = 1'b1;
        tick(99);
        chk("to_e99", 32'(bus.lock_timeout), 32'h0);
        tick(1);
        chk("to_e100", 32'(bus.lock_timeout), 32'h1);
        chk("to_e100_state", 32'(bus.seq_state), 32'h0);
        bus.pll_locked = 1'b1;
        wait_run(100);
        chk("to_after_run", 32'(bus.lock_timeout), 32'h1);
        chk("to_after_stage", 32'(bus.stage_rst_n), 32'hF);
        rst_n = 1'b0;
        tick(1);
        chk("to_cleared", 32'(bus.lock_timeout), 32'h0);
        chk("to_rst_stage", 32'(bus.stage_rst_n), 32'h0);
        chk("to_rst_done", 32'(bus.seq_done), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised power-up and recovery reset sequencer for the Hermes Lite board wrappers; it replaces the ad-hoc reset handling built from rstclk, extreset and IF_locked.
- It waits for the IF PLL lock to be stable, then releases NSTAGE active-low reset domains one at a time at fixed intervals (for example AD9866 SPI, PHY, core, receivers).
- It re-sequences from scratch on loss of lock, a debounced external reset, or a software reset pulse.
- It sits in the board wrapper beside the IF PLL, clocked from slowclk.

Parameters:
- NSTAGE, 4, number of sequenced reset outputs (1..8).
- CNT_W, 16, width of the shared interval/filter counter.
- LOCK_FILTER, 256, consecutive synchronised lock-high cycles required before sequencing (must be < 2^CNT_W).
- STAGE_DELAY, 1000, cycles between successive stage releases (must be >= 1 and < 2^CNT_W).
- DEBOUNCE, 64, consecutive synchronised low cycles on ext_reset_n that count as a reset request.
- LOCK_TIMEOUT, 50000, cycles in WAIT_LOCK before lock_timeout is flagged.

Ports:
- rstclk  in  1  sequencer clock (slowclk).
- rst_n  in  1  synchronous active-low reset.
- pll_locked  in  1  asynchronous PLL lock; 2-FF synchronised internally.
- ext_reset_n  in  1  asynchronous external reset button, active low; 2-FF synchronised, then debounced.
- soft_reset  in  1  single-cycle synchronous request to re-sequence.
- stage_rst_n  out  NSTAGE  active-low reset per domain; bit 0 is released first.
- seq_done  out  1  high while in RUN.
- lock_timeout  out  1  sticky flag; cleared only by rst_n.
- lock_loss_cnt  out  8  count of lock-loss events in RUN; saturates at 255; cleared only by rst_n.
- seq_state  out  2  current state encoding, for LEDs.

Behaviour:
- Reset (rst_n=0 at an rstclk edge):
  - state=WAIT_LOCK; stage_rst_n=all 0; seq_done=0; lock_timeout=0; lock_loss_cnt=0; counter=0; synchronisers=0; debounce count=0.
- States (seq_state): WAIT_LOCK=0, FILTER=1, RELEASE=2, RUN=3.
- WAIT_LOCK:
  - Counter increments each cycle, saturating at LOCK_TIMEOUT.
  - When it reaches LOCK_TIMEOUT, set lock_timeout.
  - lk_s=1 (synchronised lock) -> FILTER with counter=0.
- FILTER:
  - lk_s=1 -> counter++.
  - lk_s=0 -> back to WAIT_LOCK, counter=0.
  - Counter reaching LOCK_FILTER-1 with lk_s=1 -> RELEASE with counter=0, stage index=0.
- RELEASE:
  - Counter increments each cycle.
  - When counter==STAGE_DELAY-1: set stage_rst_n[index] to 1, counter=0, index++.
  - Releasing bit NSTAGE-1 -> RUN.
  - Stage k is therefore released exactly (k+1)*STAGE_DELAY cycles after entering RELEASE.
  - Released bits stay 1 until an abort.
- RUN: seq_done=1 (registered, asserted in the first RUN cycle); stays in RUN until an abort.
- Abort conditions, evaluated in every state except WAIT_LOCK:
  - lk_s=0, debounced external request, or soft_reset=1.
  - Effect on the next edge: stage_rst_n=all 0, seq_done=0, state=WAIT_LOCK, counter=0.
  - lock_loss_cnt increments only when the abort occurs in RUN and lk_s=0 is among the causes.
  - Simultaneous causes give a single increment.
- Abort in WAIT_LOCK: external request or soft_reset only restarts the timeout counter; lock_timeout is not cleared.
- Debounce:
  - Counter increments while ext_s=0; it is cleared whenever ext_s=1.
  - The request is asserted for one cycle when the count reaches DEBOUNCE-1.
  - The request does not repeat until ext_s has returned high.
  - Holding the button keeps stage_rst_n low: while ext_s=0, FILTER and RELEASE do not advance.
- Synchroniser latency: an input edge takes effect in the state machine 2 cycles later; abort reaches the outputs 3 cycles after the input edge.
- Widths:
  - The counter is CNT_W bits and compares against parameters truncated to CNT_W.
  - lock_loss_cnt saturates at 8'hFF, with no wrap.
- rst_n overrides everything.
- soft_reset during an active debounce is treated as a single abort.

Decomposition:
- Shared package hl_reset_pkg holds:
  - state encodings WAIT_LOCK/FILTER/RELEASE/RUN;
  - default constants LOCK_FILTER_DEF, STAGE_DELAY_DEF, DEBOUNCE_DEF.
- One sub-module, sync_debounce: 2-FF synchroniser plus parametrised debounce counter with a one-shot request output.
  - Instantiated for ext_reset_n.
  - pll_locked uses a plain 2-FF synchroniser with no debounce.

Test Plan:
- Power-up with NSTAGE=4, LOCK_FILTER=8, STAGE_DELAY=10; drive pll_locked=1 at cycle 0 after reset. Required:
  - stage_rst_n goes 0000 -> 0001 -> 0011 -> 0111 -> 1111, with releases 10 cycles apart;
  - the first release lands 2+8+10 cycles after lock;
  - seq_done rises with the last release.
- Lock glitch in FILTER: drop pll_locked for 1 cycle at filter count 5 -> returns to WAIT_LOCK; full re-filter of 8 cycles; lock_loss_cnt stays 0.
- Lock loss in RUN -> stage_rst_n=0000 and seq_done=0 three cycles after the edge; lock_loss_cnt=1. After 300 forced losses, lock_loss_cnt=255.
- Button, with DEBOUNCE=4: a low pulse of 3 cycles is ignored (seq_done stays 1). A hold of 20 cycles aborts, keeps resets low during the hold, and re-sequences after release.
- soft_reset pulse in RELEASE while stage 1 is released -> all stages low next cycle; restart from WAIT_LOCK.
- No lock with LOCK_TIMEOUT=100:
  - lock_timeout=1 at cycle 100;
  - later lock still sequences normally;
  - lock_timeout stays 1 until rst_n.
